// File: rtl/burst_rw_data_pkg.sv
// Shared encodings and default DDR timing for the burst data-phase logic.
// Request codes other than READ and WRITE carry no data phase.
package ddr_package;

  localparam int CL_DEFAULT  = 11;
  localparam int CWL_DEFAULT = 9;
  localparam int BL_DEFAULT  = 8;

  typedef enum logic [1:0] {
    RW_NOP  = 2'b00,
    READ    = 2'b01,
    WRITE   = 2'b10,
    RW_RSVD = 2'b11
  } rw_request_type;

  typedef enum logic [1:0] {
    RWD_IDLE = 2'b00,
    RWD_WR   = 2'b01,
    RWD_RD   = 2'b10
  } rwd_fsm_type;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cas_lat_queue.sv
// FIFO of issued CAS commands; each entry counts down its own CL/CWL latency
// so the head reports ready exactly when its data phase is due.
module cas_lat_queue
  import ddr_package::*;
#(
  parameter int CL    = CL_DEFAULT,
  parameter int CWL   = CWL_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic       clock_t,
  input  logic       reset_n,
  input  logic       cas_rdy,
  input  logic [1:0] rw_request,
  input  logic       pop,
  output logic [1:0] head_type,
  output logic       head_ready,
  output logic       overflow
);

  localparam int CNT_W = $clog2(max_of(CL, CWL) + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CL_LOAD    = CNT_W'(CL - 1);
  localparam logic [CNT_W-1:0] CWL_LOAD   = CNT_W'(CWL - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [1:0]       type_q [DEPTH];
  logic [CNT_W-1:0] cnt_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             req_valid;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign req_valid  = cas_rdy && (rw_request == READ || rw_request == WRITE);
  assign full       = (count == FULL_COUNT);
  assign do_pop     = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push    = req_valid && (!full || do_pop);
  assign overflow   = req_valid && full && !do_pop;
  assign head_type  = type_q[rd_ptr];
  assign head_ready = (count != '0) && (cnt_q[rd_ptr] == '0);

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
      if (do_push) begin
        type_q[wr_ptr] <= rw_request;
        cnt_q[wr_ptr]  <= (rw_request == READ) ? CL_LOAD : CWL_LOAD;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/burst_rw_data.sv
// Data-phase responder: turns latency-timed CAS commands into BL-beat DQ
// write bursts or read captures, reporting completion and sticky errors.
module burst_rw_data
  import ddr_package::*;
#(
  parameter int CL    = CL_DEFAULT,
  parameter int CWL   = CWL_DEFAULT,
  parameter int BL    = BL_DEFAULT,
  parameter int DQ_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clock_t,
  input  logic            reset_n,
  input  logic            cas_rdy,
  input  logic [1:0]      rw_request,
  input  logic [DQ_W-1:0] wr_data,
  output logic            wr_pop,
  input  logic [DQ_W-1:0] dq_in,
  output logic [DQ_W-1:0] dq_out,
  output logic            dq_oe,
  output logic [DQ_W-1:0] rd_data,
  output logic            rd_valid,
  output logic            rw_done,
  output logic [1:0]      err
);

  localparam int BEAT_W = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BL - 1);

  rwd_fsm_type      state;
  rwd_fsm_type      state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_nxt;
  logic [1:0]       head_type;
  logic             head_ready;
  logic             q_overflow;
  logic             pop;
  logic             burst_active;
  logic             burst_wr;
  logic             burst_last;
  logic             collide;

  cas_lat_queue #(
    .CL   (CL),
    .CWL  (CWL),
    .DEPTH(DEPTH)
  ) u_queue (
    .clock_t   (clock_t),
    .reset_n   (reset_n),
    .cas_rdy   (cas_rdy),
    .rw_request(rw_request),
    .pop       (pop),
    .head_type (head_type),
    .head_ready(head_ready),
    .overflow  (q_overflow)
  );

  // Launching from idle makes the launch cycle itself beat 0; launching from
  // the last beat starts the next burst on the following cycle.
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat_cnt;
    pop          = 1'b0;
    burst_active = 1'b0;
    burst_wr     = 1'b0;
    burst_last   = 1'b0;
    collide      = 1'b0;
    case (state)
      RWD_IDLE: begin
        if (head_ready) begin
          pop          = 1'b1;
          burst_active = 1'b1;
          burst_wr     = (head_type == WRITE);
          state_nxt    = burst_wr ? RWD_WR : RWD_RD;
          beat_nxt     = BEAT_W'(1);
        end
      end
      default: begin
        burst_active = 1'b1;
        burst_wr     = (state == RWD_WR);
        if (beat_cnt == LAST_BEAT) begin
          burst_last = 1'b1;
          beat_nxt   = '0;
          if (head_ready) begin
            pop       = 1'b1;
            state_nxt = (head_type == WRITE) ? RWD_WR : RWD_RD;
          end else begin
            state_nxt = RWD_IDLE;
          end
        end else begin
          beat_nxt = beat_cnt + 1'b1;
          collide  = head_ready;
        end
      end
    endcase
  end

  assign dq_oe  = burst_active && burst_wr;
  assign wr_pop = dq_oe;
  assign dq_out = dq_oe ? wr_data : '0;

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RWD_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rw_done  <= 1'b0;
      err      <= 2'b00;
    end else begin
      rd_valid <= burst_active && !burst_wr;
      if (burst_active && !burst_wr) rd_data <= dq_in;
      rw_done  <= burst_last;
      err      <= err | {collide, q_overflow};
    end
  end

endmodule

// File: tb/tb_burst_rw_data.sv
// Randomized, self-checking bench for burst_rw_data against a burst-schedule
// reference model derived from CAS issue cycles and latencies.
module tb_burst_rw_data;
  import ddr_package::*;

  localparam int CL = 11, CWL = 9, BL = 8, DQ_W = 8, DEPTH = 4, MAXC = 160;

  logic            clock_t = 1'b0;
  logic            reset_n = 1'b0;
  logic            cas_rdy = 1'b0;
  logic [1:0]      rw_request = 2'b00;
  logic [DQ_W-1:0] wr_data = '0;
  logic [DQ_W-1:0] dq_in = '0;
  logic            wr_pop, dq_oe, rd_valid, rw_done;
  logic [DQ_W-1:0] dq_out, rd_data;
  logic [1:0]      err;

  burst_rw_data #(.CL(CL), .CWL(CWL), .BL(BL), .DQ_W(DQ_W), .DEPTH(DEPTH)) dut (
    .clock_t(clock_t), .reset_n(reset_n), .cas_rdy(cas_rdy), .rw_request(rw_request),
    .wr_data(wr_data), .wr_pop(wr_pop), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .rd_data(rd_data), .rd_valid(rd_valid), .rw_done(rw_done), .err(err)
  );

  always #5 clock_t = ~clock_t;

  int checks_total = 0;
  int checks_passed = 0;

  logic       cmd_v [MAXC];
  logic [1:0] cmd_t [MAXC];
  logic [7:0] wd [MAXC];
  logic [7:0] di [MAXC];
  logic       e_oe [MAXC];
  logic       e_rdv [MAXC];
  logic       e_done [MAXC];
  logic [7:0] e_rdd [MAXC];
  logic [1:0] e_err;
  int         e_bursts;
  logic       o_oe [MAXC];
  logic       o_pop [MAXC];
  logic       o_rdv [MAXC];
  logic       o_done [MAXC];
  logic [7:0] o_dout [MAXC];
  logic [7:0] o_rdd [MAXC];

  // Releases reset and leaves the bench 1 time unit after a rising edge.
  task automatic do_reset();
    reset_n = 1'b0; cas_rdy = 1'b0; rw_request = 2'b00; wr_data = '0; dq_in = '0;
    repeat (2) @(posedge clock_t);
    @(negedge clock_t);
    reset_n = 1'b1;
    @(posedge clock_t);
    #1;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      cmd_v[c] = 1'b0; cmd_t[c] = 2'b00;
      wd[c] = 8'($urandom); di[c] = 8'($urandom);
    end
  endtask

  // Bursts run in CAS order: each starts at its due cycle (issue + latency)
  // or right after the previous burst, whichever is later.
  task automatic build_model();
    int pops[$];
    int prev_end, ready, start, pop_cyc, busy, idx;
    for (int c = 0; c < MAXC; c++) begin
      e_oe[c] = 1'b0; e_rdv[c] = 1'b0; e_done[c] = 1'b0; e_rdd[c] = 8'h00;
    end
    e_err = 2'b00; e_bursts = 0; prev_end = -100;
    for (int c = 0; c < MAXC; c++) begin
      if (!(cmd_v[c] && (cmd_t[c] == READ || cmd_t[c] == WRITE))) continue;
      busy = 0;
      foreach (pops[i]) if (pops[i] > c) busy++;
      if (busy >= DEPTH) begin
        e_err[0] = 1'b1;
        continue;
      end
      ready = c + ((cmd_t[c] == READ) ? CL : CWL);
      if (ready > prev_end) begin
        start = ready; pop_cyc = ready;
      end else begin
        start = prev_end + 1; pop_cyc = prev_end;
        if (ready <= prev_end - 1) e_err[1] = 1'b1;
      end
      pops.push_back(pop_cyc);
      for (int j = 0; j < BL; j++) begin
        idx = start + j;
        if (cmd_t[c] == WRITE) begin
          if (idx < MAXC) e_oe[idx] = 1'b1;
        end else if (idx + 1 < MAXC) begin
          e_rdv[idx + 1] = 1'b1;
          e_rdd[idx + 1] = di[idx];
        end
      end
      if (start + BL < MAXC) e_done[start + BL] = 1'b1;
      e_bursts++;
      prev_end = start + BL - 1;
    end
  endtask

  task automatic run_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      cas_rdy = cmd_v[c]; rw_request = cmd_t[c]; wr_data = wd[c]; dq_in = di[c];
      @(negedge clock_t);
      o_oe[c] = dq_oe; o_pop[c] = wr_pop; o_dout[c] = dq_out;
      o_rdv[c] = rd_valid; o_rdd[c] = rd_data; o_done[c] = rw_done;
      @(posedge clock_t);
      #1;
    end
    cas_rdy = 1'b0; rw_request = 2'b00;
  endtask

  function automatic logic [19:0] exp_vec(input int c);
    return {e_oe[c], e_oe[c], e_oe[c] ? wd[c] : 8'h00, e_rdv[c], e_rdv[c] ? e_rdd[c] : 8'h00, e_done[c]};
  endfunction

  function automatic logic [19:0] obs_vec(input int c);
    return {o_oe[c], o_pop[c], o_dout[c], o_rdv[c], o_rdv[c] ? o_rdd[c] : 8'h00, o_done[c]};
  endfunction

  function automatic int count_done(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (o_done[c] === 1'b1) k++;
    return k;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; cas_rdy = 1'b1; rw_request = WRITE; wr_data = 8'h5A; dq_in = 8'h33;
    @(negedge clock_t);
    checks_total++;
    if ({dq_oe, wr_pop, dq_out, rd_valid, rd_data, rw_done} !== 20'h0)
      $display("[TB] FAIL reset_outputs got %h required 0", {dq_oe, wr_pop, dq_out, rd_valid, rd_data, rw_done});
    else checks_passed++;
    checks_total++;
    if (err !== 2'b00) $display("[TB] FAIL reset_err got %b required 00", err);
    else checks_passed++;
    repeat (12) @(negedge clock_t);
    checks_total++;
    if (dq_oe !== 1'b0 || rw_done !== 1'b0) $display("[TB] FAIL reset_hold got oe=%b done=%b required 0", dq_oe, rw_done);
    else checks_passed++;
    do_reset();
    clear_stim();
    run_cycles(20);
    checks_total++;
    if (count_done(20) !== 0 || o_oe[9] !== 1'b0 || o_oe[12] !== 1'b0)
      $display("[TB] FAIL reset_no_burst got done=%0d required 0", count_done(20));
    else checks_passed++;
  endtask

  task automatic test_single_write();
    int pops_seen = 0;
    do_reset(); clear_stim();
    cmd_v[0] = 1'b1; cmd_t[0] = WRITE;
    build_model(); run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      checks_total++;
      if (obs_vec(c) !== exp_vec(c)) $display("[TB] FAIL wr_cycle%0d got %h required %h", c, obs_vec(c), exp_vec(c));
      else checks_passed++;
      if (o_pop[c] === 1'b1) pops_seen++;
    end
    checks_total++;
    if (o_oe[8] !== 1'b0 || o_oe[9] !== 1'b1 || o_oe[16] !== 1'b1 || o_oe[17] !== 1'b0)
      $display("[TB] FAIL wr_window got %b%b%b%b required 0110", o_oe[8], o_oe[9], o_oe[16], o_oe[17]);
    else checks_passed++;
    checks_total++;
    if (pops_seen !== 8) $display("[TB] FAIL wr_pop_count got %0d required 8", pops_seen);
    else checks_passed++;
    checks_total++;
    if (o_done[17] !== 1'b1 || count_done(30) !== 1) $display("[TB] FAIL wr_done got %b/%0d required 1/1", o_done[17], count_done(30));
    else checks_passed++;
    checks_total++;
    if (o_dout[12] !== wd[12]) $display("[TB] FAIL wr_data got %h required %h", o_dout[12], wd[12]);
    else checks_passed++;
  endtask

  task automatic test_single_read();
    do_reset(); clear_stim();
    cmd_v[0] = 1'b1; cmd_t[0] = READ;
    for (int j = 0; j < BL; j++) di[CL + j] = 8'hA0 + 8'(j);
    build_model(); run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      checks_total++;
      if (obs_vec(c) !== exp_vec(c)) $display("[TB] FAIL rd_cycle%0d got %h required %h", c, obs_vec(c), exp_vec(c));
      else checks_passed++;
    end
    checks_total++;
    if (o_rdv[11] !== 1'b0 || o_rdv[12] !== 1'b1 || o_rdv[19] !== 1'b1 || o_rdv[20] !== 1'b0)
      $display("[TB] FAIL rd_window got %b%b%b%b required 0110", o_rdv[11], o_rdv[12], o_rdv[19], o_rdv[20]);
    else checks_passed++;
    checks_total++;
    if (o_rdd[12] !== 8'hA0 || o_rdd[19] !== 8'hA7) $display("[TB] FAIL rd_data got %h..%h required a0..a7", o_rdd[12], o_rdd[19]);
    else checks_passed++;
    checks_total++;
    if (o_done[19] !== 1'b1 || o_oe[11] !== 1'b0) $display("[TB] FAIL rd_done got %b required 1", o_done[19]);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    int oe_run = 0;
    do_reset(); clear_stim();
    cmd_v[0] = 1'b1; cmd_t[0] = WRITE; cmd_v[8] = 1'b1; cmd_t[8] = WRITE;
    build_model(); run_cycles(40);
    for (int c = 0; c < 40; c++) begin
      checks_total++;
      if (obs_vec(c) !== exp_vec(c)) $display("[TB] FAIL b2b_cycle%0d got %h required %h", c, obs_vec(c), exp_vec(c));
      else checks_passed++;
      if (c >= 9 && c <= 24 && o_oe[c] === 1'b1) oe_run++;
    end
    checks_total++;
    if (oe_run !== 16) $display("[TB] FAIL b2b_contiguous got %0d required 16", oe_run);
    else checks_passed++;
    checks_total++;
    if (o_done[17] !== 1'b1 || o_done[25] !== 1'b1 || count_done(40) !== 2)
      $display("[TB] FAIL b2b_done got %0d required 2", count_done(40));
    else checks_passed++;
    checks_total++;
    if (err !== 2'b00) $display("[TB] FAIL b2b_err got %b required 00", err);
    else checks_passed++;
  endtask

  task automatic test_read_collision();
    do_reset(); clear_stim();
    cmd_v[0] = 1'b1; cmd_t[0] = READ; cmd_v[4] = 1'b1; cmd_t[4] = READ;
    build_model(); run_cycles(40);
    for (int c = 0; c < 40; c++) begin
      checks_total++;
      if (obs_vec(c) !== exp_vec(c)) $display("[TB] FAIL coll_cycle%0d got %h required %h", c, obs_vec(c), exp_vec(c));
      else checks_passed++;
    end
    checks_total++;
    if (err !== 2'b10) $display("[TB] FAIL coll_err got %b required 10", err);
    else checks_passed++;
    checks_total++;
    if (o_rdv[20] !== 1'b1 || o_rdd[20] !== di[19] || o_rdd[27] !== di[26])
      $display("[TB] FAIL coll_second got %h required %h", o_rdd[20], di[19]);
    else checks_passed++;
    checks_total++;
    if (o_done[19] !== 1'b1 || o_done[27] !== 1'b1) $display("[TB] FAIL coll_done got %b%b required 11", o_done[19], o_done[27]);
    else checks_passed++;
  endtask

  task automatic test_overflow();
    do_reset(); clear_stim();
    for (int c = 0; c < 5; c++) begin cmd_v[c] = 1'b1; cmd_t[c] = WRITE; end
    build_model(); run_cycles(60);
    for (int c = 0; c < 60; c++) begin
      checks_total++;
      if (obs_vec(c) !== exp_vec(c)) $display("[TB] FAIL ovf_cycle%0d got %h required %h", c, obs_vec(c), exp_vec(c));
      else checks_passed++;
    end
    checks_total++;
    if (err[0] !== 1'b1 || err !== e_err) $display("[TB] FAIL ovf_err got %b required %b", err, e_err);
    else checks_passed++;
    checks_total++;
    if (count_done(60) !== 4) $display("[TB] FAIL ovf_bursts got %0d required 4", count_done(60));
    else checks_passed++;
  endtask

  task automatic test_mid_burst_reset();
    int activity = 0;
    do_reset(); clear_stim();
    cmd_v[0] = 1'b1; cmd_t[0] = WRITE;
    run_cycles(12);
    wr_data = wd[12];
    #1;
    checks_total++;
    if (dq_oe !== 1'b1 || dq_out !== wd[12]) $display("[TB] FAIL mid_beat3 got oe=%b data=%h required 1/%h", dq_oe, dq_out, wd[12]);
    else checks_passed++;
    reset_n = 1'b0;
    #1;
    checks_total++;
    if (dq_oe !== 1'b0 || wr_pop !== 1'b0 || dq_out !== 8'h00)
      $display("[TB] FAIL mid_drop got oe=%b pop=%b data=%h required 0", dq_oe, wr_pop, dq_out);
    else checks_passed++;
    repeat (2) @(posedge clock_t);
    @(negedge clock_t);
    reset_n = 1'b1;
    @(posedge clock_t);
    #1;
    clear_stim();
    run_cycles(30);
    for (int c = 0; c < 30; c++) if (o_oe[c] === 1'b1 || o_done[c] === 1'b1 || o_pop[c] === 1'b1) activity++;
    checks_total++;
    if (activity !== 0) $display("[TB] FAIL mid_after got %0d active cycles required 0", activity);
    else checks_passed++;
  endtask

  task automatic test_random();
    int dens;
    for (int it = 0; it < 4; it++) begin
      dens = 15 + it * 20;
      do_reset(); clear_stim();
      for (int c = 0; c < 40; c++)
        if ($urandom_range(99) < dens) begin cmd_v[c] = 1'b1; cmd_t[c] = 2'($urandom); end
      build_model(); run_cycles(150);
      for (int c = 0; c < 150; c++) begin
        checks_total++;
        if (obs_vec(c) !== exp_vec(c)) $display("[TB] FAIL rand%0d_cycle%0d got %h required %h", it, c, obs_vec(c), exp_vec(c));
        else checks_passed++;
      end
      checks_total++;
      if (err !== e_err) $display("[TB] FAIL rand%0d_err got %b required %b", it, err, e_err);
      else checks_passed++;
      checks_total++;
      if (count_done(150) !== e_bursts) $display("[TB] FAIL rand%0d_bursts got %0d required %0d", it, count_done(150), e_bursts);
      else checks_passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_read_collision();
    test_overflow();
    test_mid_burst_reset();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
